mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer_pkg.sv | 33 +++
 rtl/mdu_div_step.sv | 27 ++
 rtl/mdu_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: Funct codes,
// FSM state encoding, iteration count and a magnitude helper.
// Build option: define MDU_DIV_EN to include the DIV state and divider.
package mdu_sequencer_pkg;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1a;
   localparam logic [5:0] F_DIVU  = 6'h1b;

   localparam int ITER_CNT = 32;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_FIX  = 3'd2,
      S_DONE = 3'd3
`ifdef MDU_DIV_EN
      ,
      S_DIV  = 3'd4
`endif
   } state_t;

   // Two's-complement magnitude when the operand is treated as signed.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, record the quotient bit.
// Only present when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module mdu_div_step (
   input  logic [31:0] rem,
   input  logic [31:0] quo,
   input  logic [31:0] divisor,
   output logic [31:0] rem_nxt,
   output logic [31:0] quo_nxt
);

   logic [32:0] shifted;
   logic [31:0] diff;
   logic        fits;

   // Trial subtract; the low 32 bits of the difference are exact whenever it fits.
   always_comb begin
      shifted = {rem, quo[31]};
      diff    = shifted[31:0] - divisor;
      fits    = (shifted >= {1'b0, divisor});
      rem_nxt = fits ? diff : shifted[31:0];
      quo_nxt = {quo[30:0], fits};
   end

endmodule
`endif

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers.
// Build option: MDU_DIV_EN enables div/divu; without it they are no-ops
// and div_zero is tied low.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; mthi/mtlo write HI/LO directly
// MUL    | 32 shift-add steps on operand magnitudes
// DIV    | 32 restoring-subtract steps (MDU_DIV_EN builds only)
// FIX    | sign correction, HI/LO written on exit
// DONE   | one-cycle done pulse, then back to IDLE
module mdu_sequencer
   import mdu_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  Funct,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] rdata
);

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [5:0]  op;
   logic        a_sign;
   logic [31:0] b_reg;
   logic [31:0] acc_hi, acc_lo;
   logic [31:0] hi, lo;

   logic        is_mul_req, is_div_req, req_signed;
   logic        op_signed, neg_a, neg_b, last_iter;
   logic [31:0] mag_b;
   logic [32:0] mul_sum;
   logic [63:0] prod, prod_fix;
   logic [31:0] hi_fix, lo_fix;

   assign is_mul_req = (Funct == F_MULT) || (Funct == F_MULTU);
   assign req_signed = (Funct == F_MULT) || (Funct == F_DIV);
   assign op_signed  = (op == F_MULT) || (op == F_DIV);
   assign neg_a      = op_signed & a_sign;
   assign neg_b      = op_signed & b_reg[31];
   assign mag_b      = mag32(b_reg, op_signed);
   assign last_iter  = (cnt == 5'(ITER_CNT - 1));
   assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : 33'd0);
   assign prod       = {acc_hi, acc_lo};
   assign rdata      = (Funct == F_MFHI) ? hi : lo;

`ifdef MDU_DIV_EN
   logic [31:0] a_reg;
   logic [31:0] rem_nxt, quo_nxt;
   logic        is_div_op;

   assign is_div_req = (Funct == F_DIV) || (Funct == F_DIVU);
   assign is_div_op  = (op == F_DIV) || (op == F_DIVU);
   assign div_zero   = (state == S_DONE) && is_div_op && (b_reg == 32'd0);

   mdu_div_step u_div_step (
      .rem     (acc_hi),
      .quo     (acc_lo),
      .divisor (mag_b),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );
`else
   assign is_div_req = 1'b0;
   assign div_zero   = 1'b0;
`endif

   // Sign-corrected results loaded into HI/LO on the FIX -> DONE edge.
   always_comb begin
      prod_fix = (neg_a ^ neg_b) ? (64'd0 - prod) : prod;
      hi_fix   = prod_fix[63:32];
      lo_fix   = prod_fix[31:0];
`ifdef MDU_DIV_EN
      if (is_div_op) begin
         if (b_reg == 32'd0) begin
            lo_fix = 32'hFFFF_FFFF;
            hi_fix = a_reg;
         end else begin
            lo_fix = (neg_a ^ neg_b) ? (32'd0 - acc_lo) : acc_lo;
            hi_fix = neg_a ? (32'd0 - acc_hi) : acc_hi;
         end
      end
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && is_mul_req) state_nxt = S_MUL;
`ifdef MDU_DIV_EN
            else if (start && is_div_req) state_nxt = S_DIV;
`endif
         end
         S_MUL: begin
            busy = 1'b1;
            if (last_iter) state_nxt = S_FIX;
         end
`ifdef MDU_DIV_EN
         S_DIV: begin
            busy = 1'b1;
            if (last_iter) state_nxt = S_FIX;
         end
`endif
         S_FIX: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, iteration datapath and HI/LO registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= 5'd0;
         op     <= 6'd0;
         a_sign <= 1'b0;
         b_reg  <= 32'd0;
         acc_hi <= 32'd0;
         acc_lo <= 32'd0;
         hi     <= 32'd0;
         lo     <= 32'd0;
`ifdef MDU_DIV_EN
         a_reg  <= 32'd0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start && (is_mul_req || is_div_req)) begin
                  op     <= Funct;
                  a_sign <= in_a[31];
                  b_reg  <= in_b;
                  cnt    <= 5'd0;
                  acc_hi <= 32'd0;
                  acc_lo <= mag32(in_a, req_signed);
`ifdef MDU_DIV_EN
                  a_reg  <= in_a;
`endif
               end else if (start && (Funct == F_MTHI)) begin
                  hi <= in_a;
               end else if (start && (Funct == F_MTLO)) begin
                  lo <= in_a;
               end
            end
            S_MUL: begin
               cnt              <= cnt + 5'd1;
               {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
               cnt    <= cnt + 5'd1;
               acc_hi <= rem_nxt;
               acc_lo <= quo_nxt;
            end
`endif
            S_FIX: begin
               hi <= hi_fix;
               lo <= lo_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares on done or on a read request.
module tb_mdu_sequencer;
   import mdu_sequencer_pkg::*;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
      logic        dz;
      int          start_cyc;
      int          tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [5:0]  Funct;
   logic [31:0] in_a, in_b;
   logic        busy, done, div_zero;
   logic [31:0] rdata;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   tag_n = 0;
   logic rd_req = 1'b0;
   logic busy_watch = 1'b0;
   logic busy_hit = 1'b0;
   logic prev_done = 1'b0;

   mdu_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .Funct    (Funct),
      .in_a     (in_a),
      .in_b     (in_b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .rdata    (rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
   endtask

   // Monitor: compares whenever the DUT signals done or the bench requests a read.
   always @(negedge clk) begin
      if (busy_watch && busy) busy_hit = 1'b1;
      if (done) begin
         if (prev_done) begin
            n_total++;
            $display("FAIL done_width: done high on consecutive cycles at cycle %0d, expected a single-cycle pulse", cyc);
         end
         if (sb.size() == 0 || sb[0].is_rd) begin
            n_total++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk($sformatf("op%0d_lo", mon_e.tag), rdata, mon_e.data);
            chk($sformatf("op%0d_div_zero", mon_e.tag), {31'd0, div_zero}, {31'd0, mon_e.dz});
            chk($sformatf("op%0d_latency", mon_e.tag), 32'(cyc - mon_e.start_cyc), 32'd34);
         end
      end
      if (rd_req) begin
         if (sb.size() == 0 || !sb[0].is_rd) begin
            n_total++;
            $display("FAIL read_order: read at cycle %0d with no matching expectation, expected a queued read", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk($sformatf("rd%0d_rdata", mon_e.tag), rdata, mon_e.data);
         end
      end
      prev_done = done;
   end

   task automatic rd(input logic [5:0] f, input logic [31:0] exp);
      exp_t e;
      @(posedge clk); #1;
      Funct = f;
      start = 1'b0;
      e.is_rd = 1'b1; e.data = exp; e.dz = 1'b0; e.start_cyc = cyc; e.tag = tag_n++;
      sb.push_back(e);
      rd_req = 1'b1;
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic mt(input logic [5:0] f, input logic [31:0] v);
      @(posedge clk); #1;
      Funct = f; in_a = v; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi_e,
                         input logic [31:0] lo_e, input logic dz_e, input int inject);
      exp_t e;
      @(posedge clk); #1;
      Funct = f; in_a = a; in_b = b; start = 1'b1;
      e.is_rd = 1'b0; e.data = lo_e; e.dz = dz_e; e.start_cyc = cyc; e.tag = tag_n++;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      if (inject > 0) begin
         repeat (inject - 1) @(posedge clk);
         #1;
         Funct = F_MULTU; in_a = 32'd7; in_b = 32'd9; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0; Funct = f; in_a = a; in_b = b;
      end
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL %s_timeout: no done within 60 cycles, expected done", nm);
         sb.delete();
      end
      rd(F_MFHI, hi_e);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; Funct = F_MFLO; in_a = 32'd0; in_b = 32'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
      rd(F_MFHI, 32'd0);
      rd(F_MFLO, 32'd0);

      run_op("mult_m1x2", F_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 10);
      run_op("multu_m1x2", F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, 0);
      run_op("mult_m3x5", F_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
      run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 0);
      run_op("multu_x9", F_MULTU, 32'h1234_5678, 32'd9, 32'd0, 32'hA3D7_0A38, 1'b0, 0);

      busy_hit = 1'b0; busy_watch = 1'b1;
      mt(F_MTHI, 32'h0000_1234);
      rd(F_MFHI, 32'h0000_1234);
      mt(F_MTLO, 32'h0000_CAFE);
      rd(F_MFLO, 32'h0000_CAFE);
      mt(F_MFHI, 32'h0000_0BAD);
      mt(6'h3f, 32'h0000_0BAD);
`ifndef MDU_DIV_EN
      @(posedge clk); #1;
      Funct = F_DIVU; in_a = 32'd100; in_b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
`endif
      rd(F_MFHI, 32'h0000_1234);
      rd(F_MFLO, 32'h0000_CAFE);
      busy_watch = 1'b0;
      chk("noop_busy_seen", {31'd0, busy_hit}, 32'd0);

`ifdef MDU_DIV_EN
      run_op("div_m7d2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
      run_op("divu_100d7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
      run_op("divu_5d0", F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
      run_op("div_m7d0", F_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0);
      run_op("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0);
`endif

      // Abort a multiply with reset; HI/LO were zero beforehand and must stay zero.
      mt(F_MTHI, 32'd0);
      mt(F_MTLO, 32'd0);
      @(posedge clk); #1;
      Funct = F_MULT; in_a = 32'd3; in_b = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (40) @(posedge clk);
      rd(F_MFHI, 32'd0);
      rd(F_MFLO, 32'd0);

      // Reset wins over a same-cycle mthi, and clears a non-zero HI.
      mt(F_MTHI, 32'h0000_0055);
      rd(F_MFHI, 32'h0000_0055);
      @(posedge clk); #1;
      reset = 1'b1; Funct = F_MTHI; in_a = 32'h0000_0077; start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      rd(F_MFHI, 32'd0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
